ripple_count_monitor: RTL and testbench

RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

---
 rtl/ripple_count_monitor.sv | 141 ++++++++++++++
 tb/tb_ripple_count_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
// Samples a free-running count from an upstream ripple counter in another
// clock domain. The block keeps only values that hold steady for two samples,
// counts wrap-arounds to extend the range, and offers each new value on a
// valid/ready output. Values that arrive while the output is stalled are
// dropped and recorded in a sticky overrun flag.
module ripple_count_monitor #(
  parameter int WIDTH     = 4,
  parameter int EXT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           q_in,
  input  logic                       out_ready,
  input  logic                       ovr_clr,
  output logic                       out_valid,
  output logic [EXT_WIDTH+WIDTH-1:0] out_data,
  output logic                       overrun,
  output logic [EXT_WIDTH-1:0]       wrap_cnt
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Three-stage sampling pipeline. s1 may be metastable or skewed; s2 and s3
  // are compared to reject samples taken mid-ripple.
  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] acc;
  state_t           state, state_nxt;

  // Counts edges since reset until s3 holds a real post-reset sample. Without
  // it, the zeros from reset would pass as a stable baseline.
  logic [1:0]       fill_cnt;

  logic [WIDTH-1:0]           acc_nxt;
  logic [EXT_WIDTH-1:0]       wrap_nxt;
  logic [EXT_WIDTH+WIDTH-1:0] out_data_nxt;
  logic                       out_valid_nxt;
  logic                       overrun_nxt;

  logic stable;
  logic pipe_full;
  logic accept;
  logic wrap_inc;
  logic can_load;
  logic drop;

  assign stable    = (s2 == s3);
  assign pipe_full = (fill_cnt == 2'd3);

  // Sampling pipeline and fill counter; these carry no decisions.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge; blocking here would let s2 see
    // the new s1 in the same edge and collapse the pipeline.
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      fill_cnt <= '0;
    end else begin
      s1 <= q_in;
      s2 <= s1;
      s3 <= s2;
      if (!pipe_full) fill_cnt <= fill_cnt + 2'd1;
    end
  end

  // Next-state, accept/wrap detection and output-register update logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    state_nxt     = state;
    acc_nxt       = acc;
    wrap_nxt      = wrap_cnt;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    overrun_nxt   = overrun;
    accept        = 1'b0;
    wrap_inc      = 1'b0;
    can_load      = !out_valid || out_ready;
    drop          = 1'b0;

    unique case (state)
      INIT: begin
        // First trustworthy stable value becomes the baseline, silently.
        if (pipe_full && stable) begin
          acc_nxt   = s3;
          state_nxt = RUN;
        end
      end
      RUN: begin
        accept = stable && (s3 != acc);
      end
      default: state_nxt = INIT;
    endcase

    if (accept) begin
      acc_nxt  = s3;
      // Any numeric decrease is a wrap, including an upstream reset.
      wrap_inc = (s3 < acc);
      wrap_nxt = wrap_cnt + EXT_WIDTH'(wrap_inc);
    end

    // A transfer frees the output; an accept in the same edge may refill it.
    if (out_valid && out_ready) out_valid_nxt = 1'b0;

    if (accept && can_load) begin
      out_data_nxt  = {wrap_nxt, s3};
      out_valid_nxt = 1'b1;
    end

    drop = accept && !can_load;

    // A drop in the same edge as a clear wins, so no loss goes unreported.
    if (drop)         overrun_nxt = 1'b1;
    else if (ovr_clr) overrun_nxt = 1'b0;
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      acc       <= '0;
      wrap_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      wrap_cnt  <= wrap_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Testbench for ripple_count_monitor. Stimulus pushes the expected output
// words into a queue; a monitor pops and compares on every transfer.
module tb_ripple_count_monitor;

  localparam int WIDTH     = 4;
  localparam int EXT_WIDTH = 8;
  localparam int DW        = EXT_WIDTH + WIDTH;

  logic                 clk;
  logic                 reset;
  logic [WIDTH-1:0]     q_in;
  logic                 out_ready;
  logic                 ovr_clr;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 overrun;
  logic [EXT_WIDTH-1:0] wrap_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  ripple_count_monitor #(.WIDTH(WIDTH), .EXT_WIDTH(EXT_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overrun   (overrun),
    .wrap_cnt  (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: each valid && ready seen at a falling edge is one
  // transfer at the following rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got 0x%03h, expected none (t=%0t)", out_data, $time);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [EXT_WIDTH-1:0] w;

  initial begin
    reset     = 1'b1;
    q_in      = 4'd5;
    out_ready = 1'b1;
    ovr_clr   = 1'b0;
    tick(2);

    // Reset state.
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_overrun",   32'(overrun),   0);
    check("rst_wrap_cnt",  32'(wrap_cnt),  0);

    // Steady 5 after release: baseline only, never an output.
    reset = 1'b0;
    tick(10);
    check("init_no_valid", 32'(out_valid), 0);
    check("init_wrap_cnt", 32'(wrap_cnt),  0);

    // 5 -> 6: output after the fourth edge, for exactly one cycle.
    exp_q.push_back(12'h006);
    q_in = 4'd6;
    tick(3);
    check("lat_not_yet", 32'(out_valid), 0);
    tick(1);
    check("lat_valid",   32'(out_valid), 1);
    check("lat_data",    32'(out_data),  32'h006);
    tick(1);
    check("lat_one_cyc", 32'(out_valid), 0);

    // 14, 15, 0, 1: one wrap at 15 -> 0.
    exp_q.push_back(12'h00E); q_in = 4'd14; tick(4);
    exp_q.push_back(12'h00F); q_in = 4'd15; tick(4);
    exp_q.push_back(12'h010); q_in = 4'd0;  tick(4);
    exp_q.push_back(12'h011); q_in = 4'd1;  tick(4);
    tick(2);
    check("seq_wrap_cnt", 32'(wrap_cnt), 1);

    // 7 -> glitch 0 for one cycle -> 8: the glitch is never stable.
    q_in = 4'd7;
    do_reset();
    tick(6);
    q_in = 4'd0;
    tick(1);
    exp_q.push_back(12'h008);
    q_in = 4'd8;
    tick(6);
    check("glitch_wrap_cnt", 32'(wrap_cnt), 0);
    check("glitch_drained",  32'(out_valid), 0);

    // Stalled output: 3 -> 4 -> 5 keeps 0x004, sets overrun.
    q_in = 4'd3;
    do_reset();
    tick(6);
    out_ready = 1'b0;
    q_in = 4'd4;
    tick(4);
    check("stall_valid", 32'(out_valid), 1);
    check("stall_data",  32'(out_data),  32'h004);
    check("stall_ovr0",  32'(overrun),   0);
    q_in = 4'd5;
    tick(4);
    check("stall_hold",  32'(out_data),  32'h004);
    check("stall_ovr1",  32'(overrun),   1);
    check("stall_wrap",  32'(wrap_cnt),  0);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    check("ovr_cleared", 32'(overrun),   0);

    // Clear coinciding with a drop: the drop wins.
    q_in = 4'd6;
    tick(3);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    check("ovr_drop_wins", 32'(overrun), 1);
    check("ovr_hold_data", 32'(out_data), 32'h004);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    check("ovr_cleared2",  32'(overrun), 0);

    // Release the stall: the held 0x004 is consumed.
    exp_q.push_back(12'h004);
    out_ready = 1'b1;
    tick(1);
    check("drain_valid", 32'(out_valid), 0);

    // 256 wraps via 9 -> 2 steps; wrap_cnt passes 0xFF and returns to 0.
    w = '0;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({w, 4'h9}); q_in = 4'd9; tick(4);
      w = w + 8'd1;
      exp_q.push_back({w, 4'h2}); q_in = 4'd2; tick(4);
      if (i == 254) check("wrap_ff", 32'(wrap_cnt), 32'hFF);
    end
    tick(2);
    check("wrap_rollover", 32'(wrap_cnt), 0);

    // Reset while a sample is held: outputs clear before the next edge.
    out_ready = 1'b0;
    q_in = 4'd9;
    tick(4);
    check("pre_rst_valid", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("async_valid",   32'(out_valid), 0);
    check("async_data",    32'(out_data),  0);
    check("async_wrap",    32'(wrap_cnt),  0);
    check("async_overrun", 32'(overrun),   0);

    // Outputs stay at reset values whatever the other inputs do.
    out_ready = 1'b1;
    ovr_clr   = 1'b1;
    q_in      = 4'd3;
    tick(3);
    q_in = 4'd12;
    tick(3);
    check("rst_hold", 32'({out_valid, overrun, wrap_cnt, out_data}), 0);
    ovr_clr = 1'b0;

    // After release, a steady input is only a new baseline.
    reset = 1'b0;
    tick(10);
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_wrap",  32'(wrap_cnt),  0);

    check("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
